// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter: entry layout and grant encoding.
package wb_arb_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rn;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_W    = 2'd1,
    GNT_MDU  = 2'd2
  } gnt_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus between the W stage / MDU / ID hazard logic and the write-port arbiter.
interface wb_port_arbiter_if;
  import wb_arb_pkg::*;

  logic              wwreg;
  logic [REG_AW-1:0] wrn;
  logic [DATA_W-1:0] wd;
  logic              mdu_valid;
  logic [REG_AW-1:0] mdu_rn;
  logic [DATA_W-1:0] mdu_data;
  logic              mdu_ready;
  logic              rf_we;
  logic [REG_AW-1:0] rf_wn;
  logic [DATA_W-1:0] rf_d;
  logic              stall_req;
  logic [REG_AW-1:0] q_rn;
  logic              q_hit;

  modport slave (
    input  wwreg, wrn, wd, mdu_valid, mdu_rn, mdu_data, q_rn,
    output mdu_ready, rf_we, rf_wn, rf_d, stall_req, q_hit
  );

  modport master (
    output wwreg, wrn, wd, mdu_valid, mdu_rn, mdu_data, q_rn,
    input  mdu_ready, rf_we, rf_wn, rf_d, stall_req, q_hit
  );

endinterface

// File: rtl/wb_fifo.sv
// MDU result FIFO: storage, wrapping pointers, occupancy, and per-entry rn/valid
// vectors for the ID-stage pending-write lookup.
module wb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  wb_entry_t                     entry_i,
  input  logic                          pop_i,
  output wb_entry_t                     head_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [DEPTH-1:0][REG_AW-1:0]  rn_vec_o,
  output logic [DEPTH-1:0]              valid_vec_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_EMPTY = (AW+1)'(0);

  wb_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] offs_s [DEPTH];
  logic          push_ok_s, pop_ok_s;

  assign full_o    = (count_q == CNT_FULL);
  assign empty_o   = (count_q == CNT_EMPTY);
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;
  assign head_o    = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
    else           wr_ptr_d = wr_ptr_q;
    if (pop_ok_s)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    else           rd_ptr_d = rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // An entry is live when its distance from the read pointer is below occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      offs_s[i]      = AW'(i) - rd_ptr_q;
      valid_vec_o[i] = ({1'b0, offs_s[i]} < count_q);
      rn_vec_o[i]    = mem_q[i].rn;
    end
  end

  // Pointer, occupancy and storage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= CNT_EMPTY;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok_s) mem_q[wr_ptr_q] <= entry_i;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: W stage has priority, MDU results drain from a
// FIFO on idle cycles, a starve counter forces a pipeline stall. WB_STATS_EN adds conflict_cnt.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  wb_port_arbiter_if.slave    bus
`ifdef WB_STATS_EN
  ,
  output logic [31:0]         conflict_cnt
`endif
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  wb_entry_t                   head_s, push_entry_s;
  logic                        full_s, empty_s;
  logic [DEPTH-1:0][REG_AW-1:0] rn_vec_s;
  logic [DEPTH-1:0]            valid_vec_s;
  logic                        w_win_s, push_s, pop_s, hit_s;
  gnt_e                        gnt_s;

  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_wn_q, rf_wn_d;
  logic [DATA_W-1:0] rf_d_q, rf_d_d;
  logic [3:0]        starve_q, starve_d;
  logic              stall_q, stall_d;

  // Writes to r0 are architecturally void, so neither source may claim the port for them.
  assign w_win_s      = bus.wwreg && (bus.wrn != 5'd0);
  assign push_s       = bus.mdu_valid && !full_s && (bus.mdu_rn != 5'd0);
  assign pop_s        = (gnt_s == GNT_MDU);
  assign push_entry_s = '{rn: bus.mdu_rn, data: bus.mdu_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_s),
    .entry_i     (push_entry_s),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .full_o      (full_s),
    .empty_o     (empty_s),
    .rn_vec_o    (rn_vec_s),
    .valid_vec_o (valid_vec_s)
  );

  // Grant selection on the current cycle's inputs.
  always_comb begin
    gnt_s = GNT_NONE;
    if (w_win_s)       gnt_s = GNT_W;
    else if (!empty_s) gnt_s = GNT_MDU;
    else               gnt_s = GNT_NONE;
  end

  // Winner's write is registered; address/data hold when nobody wins.
  always_comb begin
    rf_we_d = 1'b0;
    rf_wn_d = rf_wn_q;
    rf_d_d  = rf_d_q;
    case (gnt_s)
      GNT_W: begin
        rf_we_d = 1'b1;
        rf_wn_d = bus.wrn;
        rf_d_d  = bus.wd;
      end
      GNT_MDU: begin
        rf_we_d = 1'b1;
        rf_wn_d = head_s.rn;
        rf_d_d  = head_s.data;
      end
      default: begin
        rf_we_d = 1'b0;
        rf_wn_d = rf_wn_q;
        rf_d_d  = rf_d_q;
      end
    endcase
  end

  // Starve counter and stall request; stall rises as the counter saturates.
  always_comb begin
    starve_d = starve_q;
    stall_d  = stall_q;
    if (pop_s || empty_s)                        starve_d = 4'd0;
    else if (w_win_s && (starve_q != STARVE_LIM)) starve_d = starve_q + 4'd1;
    else                                         starve_d = starve_q;
    if (pop_s)                           stall_d = 1'b0;
    else if (starve_d == STARVE_LIM)     stall_d = 1'b1;
    else                                 stall_d = stall_q;
  end

  // Pending-write lookup; a head popped this cycle still counts until the RF is written.
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_vec_s[i] && (rn_vec_s[i] == bus.q_rn)) hit_s = 1'b1;
      else                                             hit_s = hit_s;
    end
  end

  // Output and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q  <= 1'b0;
      rf_wn_q  <= 5'd0;
      rf_d_q   <= 32'd0;
      starve_q <= 4'd0;
      stall_q  <= 1'b0;
    end else begin
      rf_we_q  <= rf_we_d;
      rf_wn_q  <= rf_wn_d;
      rf_d_q   <= rf_d_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign bus.mdu_ready = !full_s;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_wn     = rf_wn_q;
  assign bus.rf_d      = rf_d_q;
  assign bus.stall_req = stall_q;
  assign bus.q_hit     = (bus.q_rn != 5'd0) && hit_s;

`ifdef WB_STATS_EN
  logic [31:0] conflict_q, conflict_d;

  // Cycles where the W stage held the port while MDU results were waiting.
  always_comb begin
    conflict_d = conflict_q;
    if (w_win_s && !empty_s) conflict_d = conflict_q + 32'd1;
    else                     conflict_d = conflict_q;
  end

  // Conflict statistics register.
  always_ff @(posedge clk) begin
    if (rst) conflict_q <= 32'd0;
    else     conflict_q <= conflict_d;
  end

  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench: stimulus pushes expected RF writes into a queue, a negedge
// monitor pops and compares on every rf_we; status outputs are checked inline.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus ();
`ifdef WB_STATS_EN
  logic [31:0] conflict_cnt;
`endif

  wb_port_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef WB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  wb_entry_t exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: every RF write must match the oldest expected write.
  always @(negedge clk) begin
    wb_entry_t e;
    if (bus.rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_write: got rn=%0d data=0x%0h, expected no write",
                 bus.rf_wn, bus.rf_d);
      end else begin
        e = exp_q.pop_front();
        chk("wr_rn", {27'd0, bus.rf_wn}, {27'd0, e.rn});
        chk("wr_data", bus.rf_d, e.data);
      end
    end
  end

  task automatic drive(input logic ww, input logic [4:0] wn, input logic [31:0] wdat,
                       input logic mv, input logic [4:0] mrn, input logic [31:0] md,
                       input logic ewe, input logic [4:0] ern, input logic [31:0] ed);
    bus.wwreg     = ww;
    bus.wrn       = wn;
    bus.wd        = wdat;
    bus.mdu_valid = mv;
    bus.mdu_rn    = mrn;
    bus.mdu_data  = md;
    if (ewe) exp_q.push_back('{rn: ern, data: ed});
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input logic ww, input logic [4:0] wn, input logic [31:0] wdat,
                      input logic mv, input logic [4:0] mrn, input logic [31:0] md,
                      input logic ewe, input logic [4:0] ern, input logic [31:0] ed);
    drive(ww, wn, wdat, mv, mrn, md, ewe, ern, ed);
    tick();
  endtask

  initial begin
    // Reset held two edges with an MDU result offered: it must be ignored.
    rst = 1'b1;
    bus.q_rn = 5'd6;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    tick();
    rst = 1'b0;
    chk("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
    chk("rst_rf_wn", {27'd0, bus.rf_wn}, 32'd0);
    chk("rst_rf_d", bus.rf_d, 32'd0);
    chk("rst_stall", {31'd0, bus.stall_req}, 32'd0);
    chk("rst_ready", {31'd0, bus.mdu_ready}, 32'd1);
    chk("rst_qhit", {31'd0, bus.q_hit}, 32'd0);

    // Idle-port MDU retire.
    bus.q_rn = 5'd5;
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    chk("retire_qhit_queued", {31'd0, bus.q_hit}, 32'd1);
    chk("retire_no_early_we", {31'd0, bus.rf_we}, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    #1;
    chk("retire_qhit_popping", {31'd0, bus.q_hit}, 32'd1);
    tick();
    chk("retire_qhit_gone", {31'd0, bus.q_hit}, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("idle_we", {31'd0, bus.rf_we}, 32'd0);
    chk("idle_wn_hold", {27'd0, bus.rf_wn}, 32'd5);
    chk("idle_d_hold", bus.rf_d, 32'h1234);

    // W priority, FIFO full, starvation stall, ordered drain.
    bus.q_rn = 5'd7;
    step(1'b1, 5'd3, 32'h300, 1'b1, 5'd7, 32'hA, 1'b1, 5'd3, 32'h300);
    chk("prio_ready_1", {31'd0, bus.mdu_ready}, 32'd1);
    chk("prio_qhit_7", {31'd0, bus.q_hit}, 32'd1);
    chk("prio_stall_0", {31'd0, bus.stall_req}, 32'd0);
    step(1'b1, 5'd3, 32'h301, 1'b1, 5'd8, 32'hB, 1'b1, 5'd3, 32'h301);
    chk("prio_full", {31'd0, bus.mdu_ready}, 32'd0);
    chk("prio_stall_1", {31'd0, bus.stall_req}, 32'd0);
    step(1'b1, 5'd3, 32'h302, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h302);
    chk("prio_stall_2", {31'd0, bus.stall_req}, 32'd0);
    step(1'b1, 5'd3, 32'h303, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h303);
    chk("prio_stall_3", {31'd0, bus.stall_req}, 32'd0);
    step(1'b1, 5'd3, 32'h304, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h304);
    chk("starve_stall_set", {31'd0, bus.stall_req}, 32'd1);
    chk("starve_still_full", {31'd0, bus.mdu_ready}, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hA);
    chk("starve_stall_clr", {31'd0, bus.stall_req}, 32'd0);
    chk("drain_ready", {31'd0, bus.mdu_ready}, 32'd1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hB);
    chk("drain_qhit_0", {31'd0, bus.q_hit}, 32'd0);

    // r0 filtering on both sources.
    bus.q_rn = 5'd0;
    step(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h99, 1'b1, 5'd4, 32'h44);
    chk("r0_qhit_q0", {31'd0, bus.q_hit}, 32'd0);
    bus.q_rn = 5'd9;
    #1;
    chk("r0_qhit_q9", {31'd0, bus.q_hit}, 32'd1);
    bus.q_rn = 5'd0;
    step(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'h77, 1'b1, 5'd9, 32'h99);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("r0_dropped_we", {31'd0, bus.rf_we}, 32'd0);
    chk("r0_wn_hold", {27'd0, bus.rf_wn}, 32'd9);

    // Reset with two queued entries.
    bus.q_rn = 5'd10;
    step(1'b1, 5'd3, 32'h500, 1'b1, 5'd10, 32'h10A, 1'b1, 5'd3, 32'h500);
    step(1'b1, 5'd3, 32'h501, 1'b1, 5'd11, 32'h10B, 1'b1, 5'd3, 32'h501);
    chk("mq_qhit", {31'd0, bus.q_hit}, 32'd1);
    chk("mq_full", {31'd0, bus.mdu_ready}, 32'd0);
    rst = 1'b1;
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rst = 1'b0;
    chk("mq_rst_qhit", {31'd0, bus.q_hit}, 32'd0);
    chk("mq_rst_ready", {31'd0, bus.mdu_ready}, 32'd1);
    chk("mq_rst_wn", {27'd0, bus.rf_wn}, 32'd0);
    chk("mq_rst_d", bus.rf_d, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk("mq_no_stale_we", {31'd0, bus.rf_we}, 32'd0);
    end

    chk("pending_expected", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
